rpm_gate_controller: RTL and testbench
======================================

# rpm_gate_controller

Measurement sequencer for the Hall-sensor RPM path. It conditions the raw Hall input (synchroniser plus debounce) and generates back-to-back gate windows of fixed length. It counts debounced rising edges per window, then latches the count and a scaled RPM value. Each result is presented to the downstream consumer (display or serial formatter) through a valid/ready handshake.

## Interface
- GATE_CYCLES, 50_000_000: clk cycles per measurement window; ≥ 2.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before the filtered Hall level changes; ≥ 1.
- CNT_W, 16: pulse counter width.
- RPM_SCALE, 60: constant multiplier, RPM = pulses × RPM_SCALE; must be < 2^16.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  1 = run continuous windows; 0 = stop.
- hall_in  in  1  raw Hall sensor level, asynchronous to clk.
- meas_ready  in  1  consumer accepts the result when high together with meas_valid.
- meas_valid  out  1  result registers hold an unconsumed measurement.
- pulse_count  out  CNT_W  debounced rising edges in the last completed window.
- rpm  out  CNT_W+16  pulse_count × RPM_SCALE, exact (no truncation).
- overflow  out  1  the pulse counter saturated during the reported window.
- overrun  out  1  the reported result replaced an unconsumed earlier result.
- busy  out  1  high while in COUNT.
- gate_tick  out  1  one-cycle pulse on the last cycle of every completed window.

## Operation
- Input conditioning:
  - hall_sync is hall_in after two flops.
  - The debounce counter increments each cycle while hall_sync != hall_filt and clears when they are equal.
  - When the mismatch has persisted for DEBOUNCE_CYCLES cycles, hall_filt takes hall_sync and the counter clears.
- edge = hall_filt & ~hall_filt_q, where hall_filt_q is hall_filt delayed by one cycle.
- FSM states: IDLE, COUNT.
  - IDLE: enable=1 moves to COUNT; the gate timer loads GATE_CYCLES-1 and the pulse counter loads 0.
  - COUNT: the timer decrements each cycle. Each edge increments the pulse counter, saturating at 2^CNT_W-1; an increment attempted at saturation sets the window overflow flag.
  - COUNT with timer==0 (the last window cycle): gate_tick=1, and the result is latched, including any edge on that cycle.
    - The counter, overflow flag and timer reload for the next window on the same edge.
    - The FSM stays in COUNT if enable=1, otherwise goes to IDLE.
  - COUNT with enable=0 and timer≠0: abort. Return to IDLE, discard the partial count, produce no result and no gate_tick.
- Result latch:
  - pulse_count, rpm and overflow update from the window.
  - meas_valid is set to 1.
  - overrun is set to 1 if meas_valid was 1 and was not accepted in that same cycle, otherwise 0.
- Handshake:
  - meas_valid && meas_ready clears meas_valid on the next edge.
  - Result data stays stable while meas_valid=1 until it is accepted or overwritten by a newer latch.
  - Accept and latch in the same cycle: the new result loads, meas_valid stays 1, overrun=0.
- Debounce runs in both states, so the filter is settled when a window starts.
- Deasserting enable never clears a pending meas_valid.

## Timing
- Reset values: meas_valid=0, pulse_count=0, rpm=0, overflow=0, overrun=0, busy=0, gate_tick=0, state IDLE.
  - Synchroniser, hall_filt and hall_filt_q all reset to 0; the debounce counter resets to 0.
- hall_in edge to counted edge: 2 (sync) + DEBOUNCE_CYCLES cycles.
- enable sampled high in IDLE at edge t:
  - busy=1 from t+1.
  - The window covers cycles t+1 … t+GATE_CYCLES.
  - gate_tick=1 during cycle t+GATE_CYCLES.
  - meas_valid and the result are visible from t+GATE_CYCLES+1.
- Continuous operation: windows are exactly GATE_CYCLES long with no gap cycles.
- rpm is registered together with pulse_count; no additional latency.
- Reset mid-window or mid-handshake: all state returns to reset values immediately; no result is produced.

## Test plan
Bench parameters: GATE_CYCLES=1000, DEBOUNCE_CYCLES=4, CNT_W=8, RPM_SCALE=60.

- Clean pulses: enable at t0, then 5 hall pulses (20 cycles high, 20 low) inside the window.
  - Required: gate_tick at t0+1000, meas_valid at t0+1001.
  - Result: pulse_count=5, rpm=300, overflow=0, overrun=0.
- Glitch rejection: 10 high glitches of 3 cycles each, plus 2 pulses of 6 cycles high.
  - Required: pulse_count=2, rpm=120.
- Saturation: 300 clean pulses (1 high, 1 low after sync, ≥5 cycles each level) spread across a window with GATE_CYCLES raised to 4000.
  - Required: pulse_count=255, rpm=15300, overflow=1.
- Overrun: meas_ready held 0 for two windows.
  - Required: the second latch gives overrun=1 with the new count.
  - meas_ready=1 for one cycle drops meas_valid on the next edge.
  - An accept coinciding with a latch keeps meas_valid=1 with overrun=0.
- Abort: enable→0 at window cycle 500.
  - Required: busy=0 next cycle, no gate_tick, no meas_valid, and a pending prior result is preserved.
  - Re-enable starts a fresh 1000-cycle window.
- Reset mid-window: rst asserted at cycle 700 with a count of 3.
  - Required: all outputs are 0 asynchronously and the FSM is in IDLE.

Source files
------------

// File: rtl/rpm_gate_controller_if.sv
// Result handshake bundle between the RPM gate controller and its consumer.
// The master drives the latched measurement and meas_valid; the slave returns meas_ready.
interface rpm_gate_controller_if #(
  parameter int CNT_W = 16
);
  logic             meas_valid;
  logic             meas_ready;
  logic [CNT_W-1:0] pulse_count;
  logic [CNT_W+15:0] rpm;
  logic             overflow;
  logic             overrun;

  modport master (
    output meas_valid,
    output pulse_count,
    output rpm,
    output overflow,
    output overrun,
    input  meas_ready
  );

  modport slave (
    input  meas_valid,
    input  pulse_count,
    input  rpm,
    input  overflow,
    input  overrun,
    output meas_ready
  );
endinterface

// File: rtl/rpm_gate_controller.sv
// Hall-sensor RPM measurement sequencer: synchronises and debounces the raw
// Hall level, counts filtered rising edges over back-to-back fixed gate
// windows, and hands each window's count and scaled RPM to a consumer
// through a valid/ready handshake.
module rpm_gate_controller #(
  parameter int GATE_CYCLES     = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16,
  parameter int RPM_SCALE       = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic hall_in,
  output logic busy,
  output logic gate_tick,
  rpm_gate_controller_if.master meas
);

  localparam int TIMER_W = $clog2(GATE_CYCLES);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(GATE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [15:0]        SCALE      = 16'(RPM_SCALE);

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  state_t state;

  logic                hall_meta;
  logic                hall_sync;
  logic                hall_filt;
  logic                hall_filt_q;
  logic [DB_W-1:0]     db_cnt;
  logic                hall_edge;

  logic [TIMER_W-1:0]  timer;
  logic [CNT_W-1:0]    pulse_cnt;
  logic                win_ovf;

  logic                cnt_at_max;
  logic [CNT_W-1:0]    cnt_next;
  logic                ovf_next;
  logic [CNT_W+15:0]   rpm_next;

  // Two-flop synchroniser for the asynchronous Hall input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hall_meta <= 1'b0;
      hall_sync <= 1'b0;
    end else begin
      hall_meta <= hall_in;
      hall_sync <= hall_meta;
    end
  end

  // Debounce: the filtered level follows the synchronised level only after
  // it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt      <= '0;
      hall_filt   <= 1'b0;
      hall_filt_q <= 1'b0;
    end else begin
      hall_filt_q <= hall_filt;
      if (hall_sync == hall_filt) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        hall_filt <= hall_sync;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign hall_edge = hall_filt & ~hall_filt_q;

  // Window count including this cycle's edge, so the latch on the last
  // window cycle and the running counter share one saturating path.
  always_comb begin
    cnt_at_max = (pulse_cnt == CNT_MAX);
    cnt_next   = pulse_cnt;
    if (hall_edge && !cnt_at_max) begin
      cnt_next = pulse_cnt + 1'b1;
    end
    ovf_next = win_ovf | (hall_edge & cnt_at_max);
    rpm_next = (CNT_W+16)'(cnt_next) * (CNT_W+16)'(SCALE);
  end

  // Gate sequencer, window counter and result/handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      timer            <= '0;
      pulse_cnt        <= '0;
      win_ovf          <= 1'b0;
      busy             <= 1'b0;
      gate_tick        <= 1'b0;
      meas.meas_valid  <= 1'b0;
      meas.pulse_count <= '0;
      meas.rpm         <= '0;
      meas.overflow    <= 1'b0;
      meas.overrun     <= 1'b0;
    end else begin
      gate_tick <= 1'b0;
      // An accept clears valid unless a latch below reloads it on the same edge.
      if (meas.meas_valid && meas.meas_ready) begin
        meas.meas_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (enable) begin
            state     <= COUNT;
            busy      <= 1'b1;
            timer     <= TIMER_LOAD;
            pulse_cnt <= '0;
            win_ovf   <= 1'b0;
          end
        end
        COUNT: begin
          if (timer == '0) begin
            meas.pulse_count <= cnt_next;
            meas.rpm         <= rpm_next;
            meas.overflow    <= ovf_next;
            meas.overrun     <= meas.meas_valid & ~meas.meas_ready;
            meas.meas_valid  <= 1'b1;
            timer            <= TIMER_LOAD;
            pulse_cnt        <= '0;
            win_ovf          <= 1'b0;
            if (!enable) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            timer     <= timer - 1'b1;
            pulse_cnt <= cnt_next;
            win_ovf   <= ovf_next;
            // Registered tick: raised on entry to the timer==0 cycle, which
            // can then only end in a completed window.
            gate_tick <= (timer == TIMER_ONE);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rpm_gate_controller.sv
// Testbench for rpm_gate_controller: two instances (1000- and 4000-cycle
// gates) share stimulus; the selected one is checked against a window-level
// reference model through a result scoreboard and per-cycle status checks.
module tb_rpm_gate_controller;

  localparam int GA = 1000;
  localparam int GB = 4000;
  localparam int D  = 4;
  localparam int CW = 8;
  localparam int SC = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic hall = 1'b0;
  logic ready = 1'b0;
  logic sel = 1'b0;
  logic en_a, en_b;
  logic busy_a, tick_a, busy_b, tick_b;

  rpm_gate_controller_if #(.CNT_W(CW)) ifa ();
  rpm_gate_controller_if #(.CNT_W(CW)) ifb ();

  assign en_a = en & ~sel;
  assign en_b = en & sel;
  assign ifa.meas_ready = ready;
  assign ifb.meas_ready = ready;

  rpm_gate_controller #(.GATE_CYCLES(GA), .DEBOUNCE_CYCLES(D), .CNT_W(CW), .RPM_SCALE(SC)) dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .hall_in(hall),
    .busy(busy_a), .gate_tick(tick_a), .meas(ifa)
  );

  rpm_gate_controller #(.GATE_CYCLES(GB), .DEBOUNCE_CYCLES(D), .CNT_W(CW), .RPM_SCALE(SC)) dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .hall_in(hall),
    .busy(busy_b), .gate_tick(tick_b), .meas(ifb)
  );

  always #5 clk = ~clk;

  logic m_valid, m_busy, m_tick, m_ovf, m_ovr;
  logic [CW-1:0] m_count;
  logic [CW+15:0] m_rpm;
  assign m_valid = sel ? ifb.meas_valid  : ifa.meas_valid;
  assign m_busy  = sel ? busy_b          : busy_a;
  assign m_tick  = sel ? tick_b          : tick_a;
  assign m_ovf   = sel ? ifb.overflow    : ifa.overflow;
  assign m_ovr   = sel ? ifb.overrun     : ifa.overrun;
  assign m_count = sel ? ifb.pulse_count : ifa.pulse_count;
  assign m_rpm   = sel ? ifb.rpm         : ifa.rpm;

  typedef struct { int cnt; int rpm; bit ovf; bit ovr; } res_t;
  typedef struct { bit lvl; int w; } seg_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (window level, edge-numbered).
  int     g = GA;
  longint edge_n = 0;
  bit     running = 0;
  longint win_start = 0;
  longint win_end = 0;
  bit     pend = 0;
  bit     exp_busy = 0;
  bit     exp_tick = 0;
  longint rise_q[$];
  res_t   exp_q[$];
  seg_t   seg_q[$];
  int     cur_rem = 0;
  bit     cur_lvl = 0;
  bit     prev_tick = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected result of the window that just closed: accepted rising runs
  // whose counted edge falls inside (win_start, win_end].
  function automatic void push_result(input bit acc);
    res_t r;
    int n = 0;
    int mx = (1 << CW) - 1;
    foreach (rise_q[i]) if (rise_q[i] > win_start && rise_q[i] <= win_end) n++;
    while (rise_q.size() > 0 && rise_q[0] <= win_end) void'(rise_q.pop_front());
    r.cnt = (n > mx) ? mx : n;
    r.ovf = (n > mx);
    r.rpm = r.cnt * SC;
    r.ovr = pend && !acc;
    exp_q.push_back(r);
  endfunction

  task automatic step();
    bit acc, en_s;
    seg_t s;
    acc  = pend && ready && !rst;
    en_s = en && !rst;
    @(posedge clk);
    #1;
    edge_n++;
    if (!rst) begin
      if (running && edge_n == win_end) begin
        push_result(acc);
        pend = 1;
        if (en_s) begin
          win_start = edge_n;
          win_end   = edge_n + g;
        end else begin
          running = 0;
        end
      end else begin
        if (acc) pend = 0;
        if (running && !en_s) begin
          running = 0;
        end else if (!running && en_s) begin
          running   = 1;
          win_start = edge_n;
          win_end   = edge_n + g;
        end
      end
    end
    if (cur_rem == 0 && seg_q.size() > 0) begin
      s = seg_q.pop_front();
      cur_lvl = s.lvl;
      cur_rem = s.w;
      // A high run of at least D cycles is counted 3+D edges after it is driven.
      if (s.lvl && s.w >= D) rise_q.push_back(edge_n + 3 + D);
    end
    if (cur_rem > 0) begin
      hall = cur_lvl;
      cur_rem--;
    end else begin
      hall = 1'b0;
    end
    exp_busy = running;
    exp_tick = running && (edge_n == win_end - 1);
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic run_until(input longint e);
    while (edge_n < e) step();
  endtask

  task automatic run_until_rand(input longint e);
    while (edge_n < e) begin
      ready = 1'($urandom_range(0, 1));
      step();
    end
    ready = 1'b0;
  endtask

  task automatic add_seg(input bit lvl, input int w);
    seg_t s;
    s.lvl = lvl;
    s.w   = w;
    seg_q.push_back(s);
  endtask

  task automatic add_random(input int items);
    for (int i = 0; i < items; i++) begin
      if ($urandom_range(0, 2) == 0) add_seg(1'b1, $urandom_range(1, D - 1));
      else add_seg(1'b1, $urandom_range(D, D + 6));
      add_seg(1'b0, $urandom_range(D, D + 6));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, m_valid, 0);
    chk({tag, "_count"}, m_count, 0);
    chk({tag, "_rpm"},   m_rpm, 0);
    chk({tag, "_ovf"},   m_ovf, 0);
    chk({tag, "_ovr"},   m_ovr, 0);
    chk({tag, "_busy"},  m_busy, 0);
    chk({tag, "_tick"},  m_tick, 0);
  endtask

  // Monitor: per-cycle status checks, and a scoreboard pop whenever the DUT
  // presents a freshly latched result (the cycle after gate_tick).
  always @(negedge clk) begin
    res_t r;
    chk("busy", m_busy, exp_busy);
    chk("gate_tick", m_tick, exp_tick);
    chk("meas_valid", m_valid, pend);
    if (prev_tick && !rst) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got count %0d expected no result", m_count);
      end else begin
        r = exp_q.pop_front();
        chk("res_count", m_count, r.cnt);
        chk("res_rpm", m_rpm, r.rpm);
        chk("res_overflow", m_ovf, r.ovf);
        chk("res_overrun", m_ovr, r.ovr);
      end
    end
    prev_tick = m_tick && !rst;
  end

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: time limit reached, got %0d compared, required completion", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    longint t0, e1;
    // Reset state
    steps(3);
    chk_all_zero("reset");
    rst = 1'b0;
    steps(5);

    // Clean pulses
    add_seg(1'b0, 30);
    for (int i = 0; i < 5; i++) begin add_seg(1'b1, 20); add_seg(1'b0, 20); end
    en = 1'b1;
    step();
    t0 = edge_n;
    chk("busy_after_enable", m_busy, 1);
    run_until(t0 + GA - 1);
    chk("tick_at_t0_1000", m_tick, 1);
    step();
    chk("valid_at_t0_1001", m_valid, 1);
    chk("clean_count", m_count, 5);
    chk("clean_rpm", m_rpm, 300);

    // Glitch rejection, ready still low -> overrun on this second latch
    add_seg(1'b0, 20);
    for (int i = 0; i < 10; i++) begin add_seg(1'b1, 3); add_seg(1'b0, 8); end
    for (int i = 0; i < 2; i++) begin add_seg(1'b1, 6); add_seg(1'b0, 10); end
    run_until(win_end);
    chk("glitch_count", m_count, 2);
    chk("glitch_rpm", m_rpm, 120);
    chk("glitch_overrun", m_ovr, 1);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("valid_dropped", m_valid, 0);

    // Random window, then an accept coinciding with the next latch
    add_random(15);
    run_until(win_end);
    add_random(15);
    run_until(win_end - 1);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("valid_kept_on_accept_latch", m_valid, 1);
    chk("overrun_clear_on_accept_latch", m_ovr, 0);

    // Abort at window cycle 500 with a result pending
    add_random(10);
    run_until(win_start + 500);
    en = 1'b0;
    step();
    chk("busy_after_abort", m_busy, 0);
    steps(20);
    chk("pending_kept", m_valid, 1);

    // Re-enable: fresh full-length window, then random windows and ready
    en = 1'b1;
    step();
    t0 = edge_n;
    add_random(12);
    run_until_rand(t0 + GA - 1);
    chk("fresh_window_tick", m_tick, 1);
    run_until_rand(win_end);
    for (int k = 0; k < 3; k++) begin
      add_random($urandom_range(0, 25));
      run_until_rand(win_end);
    end

    // Edges landing on the last window cycle and on the first of the next
    e1 = win_end - 3 - D;
    add_seg(1'b0, int'(e1 - (edge_n + 1)));
    add_seg(1'b1, 6);
    add_seg(1'b0, int'((win_end + g + 1 - 3 - D) - (e1 + 6)));
    add_seg(1'b1, 6);
    add_seg(1'b0, 10);
    run_until(win_end);
    chk("last_cycle_edge_counted", m_count, 1);
    run_until(win_end);
    chk("next_window_edge_excluded", m_count, 0);
    run_until(win_end - 1);
    en = 1'b0;
    step();
    steps(5);

    // Reset mid-window
    en = 1'b1;
    step();
    t0 = edge_n;
    add_seg(1'b0, 20);
    for (int i = 0; i < 3; i++) begin add_seg(1'b1, 6); add_seg(1'b0, 10); end
    run_until(t0 + 700);
    rst = 1'b1;
    en = 1'b0;
    running = 0; pend = 0; exp_busy = 0; exp_tick = 0;
    seg_q.delete(); rise_q.delete(); cur_rem = 0; hall = 1'b0;
    #1;
    chk_all_zero("async_reset");
    steps(3);
    rst = 1'b0;
    steps(5);
    en = 1'b1;
    step();
    t0 = edge_n;
    run_until(t0 + GA - 1);
    chk("post_reset_window_tick", m_tick, 1);
    en = 1'b0;
    step();
    ready = 1'b1;
    steps(3);
    ready = 1'b0;

    // Saturation on the 4000-cycle instance
    sel = 1'b1;
    g = GB;
    steps(2);
    add_seg(1'b0, 10);
    for (int i = 0; i < 300; i++) begin add_seg(1'b1, 6); add_seg(1'b0, 6); end
    en = 1'b1;
    step();
    run_until(win_end - 1);
    en = 1'b0;
    step();
    chk("sat_count", m_count, 255);
    chk("sat_rpm", m_rpm, 15300);
    chk("sat_overflow", m_ovf, 1);
    steps(3);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
